// File: rtl/axis_video_sink_if.sv
// AXI4-Stream video bus between a pixel source and a sink.
//   tdata  [31:0] pixel word
//   tkeep  [3:0]  byte enables
//   tvalid        source word valid
//   tready        sink ready
//   tuser         start of frame (SOF)
//   tlast         end of line (EOL)
// master: source side, slave: sink side.
interface axis_video_sink_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, tkeep, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_sink.sv
// Video stream sink: accepts an AXI4-Stream pixel stream, checks the
// SOF/EOL framing against X_SIZE x Y_SIZE, sums each frame's words and
// reports frame and error statistics. tready follows a selectable pattern.
//
// Ports
//   in_stream_aclk  clock, rising edge
//   axi_resetn      async active-low reset
//   in_stream       stream slave (tdata/tkeep/tvalid/tready/tuser/tlast)
//   ready_mode      0 always ready, 1 PRBS, 2 ready after valid, 3 never
//   err_clear       sync clear of err_flags/err_count (beats new errors)
//   frame_done      one-cycle pulse on frame completion
//   frame_checksum  sum of tdata over the last completed frame
//   frame_count     completed frames, wraps
//   err_flags       sticky: [0] no SOF, [1] extra SOF, [2] no EOL,
//                   [3] early EOL, [4] timeout
//   err_count       error events, saturating
//
// state  | meaning
// IDLE   | waiting for an SOF beat; non-SOF beats are discarded as errors
// ACTIVE | inside a frame, counting words (x) and lines (y)
module axis_video_sink #(
  parameter int unsigned X_SIZE   = 150,
  parameter int unsigned Y_SIZE   = 200,
  parameter int unsigned TIMEOUT  = 10000,
  parameter logic [32:0] RND_SEED = 33'h04A4C31CA
) (
  input  logic                    in_stream_aclk,
  input  logic                    axi_resetn,
  axis_video_sink_if.slave        in_stream,
  input  logic [1:0]              ready_mode,
  input  logic                    err_clear,
  output logic                    frame_done,
  output logic [31:0]             frame_checksum,
  output logic [15:0]             frame_count,
  output logic [4:0]              err_flags,
  output logic [15:0]             err_count
);
  localparam int XW = $clog2(X_SIZE + 1);
  localparam int YW = $clog2(Y_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   acc_q, acc_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [32:0]   prbs_q;
  logic          tready_q;
  logic          done_d;
  logic [4:0]    err_ev;
  logic [2:0]    ev_n;
  logic [16:0]   cnt_sum;
  logic          accept;
  logic          sof_ends_line;
  logic          unused_keep;

  assign in_stream.tready = tready_q;
  assign accept           = in_stream.tvalid && tready_q;
  assign unused_keep      = ^in_stream.tkeep;
  // With single-word lines the SOF word can itself close line 0.
  assign sof_ends_line    = (X_SIZE == 1) && in_stream.tlast;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    err_ev  = '0;
    case (state_q)
      IDLE: begin
        tmr_d = TMR_LOAD;
        if (accept) begin
          if (in_stream.tuser) begin
            state_d = ACTIVE;
            acc_d   = in_stream.tdata;
            x_d     = sof_ends_line ? '0 : XW'(1);
            y_d     = sof_ends_line ? YW'(1) : '0;
          end else begin
            err_ev[0] = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          tmr_d = TMR_LOAD;
          if (in_stream.tuser) begin
            // Abandon the partial frame and restart on this SOF word.
            err_ev[1] = 1'b1;
            acc_d     = in_stream.tdata;
            x_d       = sof_ends_line ? '0 : XW'(1);
            y_d       = sof_ends_line ? YW'(1) : '0;
          end else begin
            acc_d = acc_q + in_stream.tdata;
            if (in_stream.tlast || (x_q >= X_LAST)) begin
              err_ev[2] = !in_stream.tlast;
              err_ev[3] = in_stream.tlast && (x_q < X_LAST);
              x_d       = '0;
              if (y_q >= Y_LAST) begin
                done_d  = 1'b1;
                state_d = IDLE;
                y_d     = '0;
              end else begin
                y_d = y_q + YW'(1);
              end
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end else if (tmr_q <= TW'(1)) begin
          // Terminal count: TIMEOUT consecutive cycles without a beat.
          err_ev[4] = 1'b1;
          tmr_d     = TMR_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
    endcase
  end

  assign ev_n    = 3'(err_ev[0]) + 3'(err_ev[1]) + 3'(err_ev[2]) +
                   3'(err_ev[3]) + 3'(err_ev[4]);
  assign cnt_sum = {1'b0, err_count} + {14'd0, ev_n};

  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      acc_q          <= '0;
      tmr_q          <= TMR_LOAD;
      prbs_q         <= RND_SEED;
      tready_q       <= 1'b0;
      frame_done     <= 1'b0;
      frame_checksum <= '0;
      frame_count    <= '0;
      err_flags      <= '0;
      err_count      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      tmr_q      <= tmr_d;
      prbs_q     <= {prbs_q[31:0], prbs_q[32] ^ ~prbs_q[19]};
      frame_done <= done_d;
      case (ready_mode)
        2'd0:    tready_q <= 1'b1;
        2'd1:    tready_q <= prbs_q[32];
        2'd2:    tready_q <= accept ? 1'b0 : in_stream.tvalid;
        default: tready_q <= 1'b0;
      endcase
      if (done_d) begin
        frame_checksum <= acc_d;
        frame_count    <= frame_count + 16'd1;
      end
      if (err_clear) begin
        err_flags <= '0;
        err_count <= '0;
      end else begin
        err_flags <= err_flags | err_ev;
        err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
    end
  end
endmodule

// File: tb/tb_axis_video_sink.sv
`timescale 1ns/1ps
module tb_axis_video_sink;
  localparam int X  = 4;
  localparam int Y  = 2;
  localparam int TO = 20;
  localparam logic [32:0] SEED = 33'h04A4C31CA;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        err_clear = 1'b0;
  logic        frame_done;
  logic [31:0] frame_checksum;
  logic [15:0] frame_count;
  logic [4:0]  err_flags;
  logic [15:0] err_count;

  int vectors = 0;
  int fails   = 0;
  int pulses  = 0;
  bit chk_en  = 0;
  bit rnd_clr = 0;

  axis_video_sink_if vif();

  axis_video_sink #(.X_SIZE(X), .Y_SIZE(Y), .TIMEOUT(TO), .RND_SEED(SEED)) dut (
    .in_stream_aclk(clk),
    .axi_resetn(rstn),
    .in_stream(vif),
    .ready_mode(mode),
    .err_clear(err_clear),
    .frame_done(frame_done),
    .frame_checksum(frame_checksum),
    .frame_count(frame_count),
    .err_flags(err_flags),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Behavioural reference: frame position as plain integers, errors as counts.
  typedef struct {
    bit          active;
    int          col;
    int          row;
    logic [31:0] sum;
    int          stall;
    logic [32:0] prbs;
    logic        tready;
    logic        done;
    logic [31:0] cks;
    logic [15:0] fcnt;
    logic [4:0]  flags;
    int          ecnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.active = 0; n.col = 0; n.row = 0; n.sum = '0; n.stall = 0;
    n.prbs = SEED; n.tready = 1'b0; n.done = 1'b0; n.cks = '0;
    n.fcnt = '0; n.flags = '0; n.ecnt = 0;
    return n;
  endfunction

  function automatic model_t model_step(model_t s, logic tv, logic [31:0] td,
                                        logic tu, logic tl, logic [1:0] md, logic clr);
    model_t n;
    logic take;
    logic [4:0] ev;
    int nev;
    n = s; n.done = 1'b0; ev = '0; nev = 0;
    take = tv && s.tready;
    n.prbs = {s.prbs[31:0], s.prbs[32] ^ ~s.prbs[19]};
    case (md)
      2'd0: n.tready = 1'b1;
      2'd1: n.tready = s.prbs[32];
      2'd2: n.tready = take ? 1'b0 : tv;
      default: n.tready = 1'b0;
    endcase
    if (!s.active) n.stall = 0;
    if (take) begin
      n.stall = 0;
      if (tu) begin
        if (s.active) ev[1] = 1'b1;
        n.active = 1; n.sum = td; n.row = 0; n.col = 1;
        if (X == 1 && tl) begin n.col = 0; n.row = 1; end
      end else if (!s.active) begin
        ev[0] = 1'b1;
      end else begin
        n.sum = s.sum + td;
        if (tl || s.col >= X - 1) begin
          if (!tl) ev[2] = 1'b1;
          else if (s.col < X - 1) ev[3] = 1'b1;
          n.col = 0;
          if (s.row >= Y - 1) begin
            n.active = 0; n.row = 0; n.done = 1'b1;
            n.cks = n.sum; n.fcnt = s.fcnt + 16'd1;
          end else begin
            n.row = s.row + 1;
          end
        end else begin
          n.col = s.col + 1;
        end
      end
    end else if (s.active) begin
      n.stall = s.stall + 1;
      if (n.stall >= TO) begin ev[4] = 1'b1; n.stall = 0; end
    end
    for (int b = 0; b < 5; b++) nev += int'(ev[b]);
    if (clr) begin
      n.flags = '0; n.ecnt = 0;
    end else begin
      n.flags = s.flags | ev;
      n.ecnt  = (s.ecnt + nev > 65535) ? 65535 : s.ecnt + nev;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= model_reset();
    else       m <= model_step(m, vif.tvalid, vif.tdata, vif.tuser, vif.tlast, mode, err_clear);
  end

  typedef struct {
    logic [1:0]  mode;
    bit          gaps;
    int          n;
    logic [15:0] sof;
    logic [15:0] eol;
    logic [31:0] base;
    logic [4:0]  x_flags;
    logic [15:0] x_ecnt;
    logic [15:0] x_frames;
    logic [31:0] x_cks;
  } vec_t;

  vec_t tv[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drive_clr();
    err_clear = rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  // Presents one beat from a negedge and returns at the negedge after it was taken.
  task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input int gap);
    logic rdy;
    for (int g = 0; g < gap; g++) begin
      vif.tvalid = 1'b0;
      drive_clr();
      @(negedge clk);
    end
    vif.tdata = d; vif.tuser = u; vif.tlast = l; vif.tvalid = 1'b1;
    vif.tkeep = 4'($urandom);
    for (int w = 0; ; w++) begin
      rdy = vif.tready;
      drive_clr();
      @(negedge clk);
      if (rdy) break;
      if (w >= 200) begin
        vectors++; fails++;
        $display("FAIL beat_accept: got no tready within 200 cycles, expected acceptance");
        break;
      end
    end
    vif.tvalid = 1'b0;
    err_clear  = 1'b0;
  endtask

  task automatic send_seq(input int n, input logic [15:0] sof, input logic [15:0] eol,
                          input logic [31:0] base, input bit gaps);
    logic [15:0] s;
    logic [15:0] e;
    s = sof; e = eol;
    for (int i = 0; i < n; i++)
      send_beat(base + 32'(i), s[i], e[i], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic send_frame(input logic [31:0] base);
    send_seq(8, 16'h0001, 16'h0088, base, 0);
  endtask

  initial begin
    int p0;
    tv[0] = '{2'd0, 1'b0,  8, 16'h0001, 16'h0088, 32'd1,         5'h00, 16'd0, 16'd1, 32'd36};
    tv[1] = '{2'd1, 1'b1,  8, 16'h0001, 16'h0088, 32'd1,         5'h00, 16'd0, 16'd1, 32'd36};
    tv[2] = '{2'd0, 1'b0, 10, 16'h0004, 16'h0220, 32'd1,         5'h01, 16'd2, 16'd1, 32'd52};
    tv[3] = '{2'd0, 1'b0, 13, 16'h0021, 16'h1104, 32'd1,         5'h0A, 16'd2, 16'd1, 32'd76};
    tv[4] = '{2'd0, 1'b0,  8, 16'h0001, 16'h0000, 32'd1,         5'h04, 16'd2, 16'd1, 32'd36};
    tv[5] = '{2'd2, 1'b0,  8, 16'h0001, 16'h0088, 32'd100,       5'h00, 16'd0, 16'd1, 32'd828};
    tv[6] = '{2'd0, 1'b0,  6, 16'h0001, 16'h0022, 32'd10,        5'h08, 16'd1, 16'd1, 32'd75};
    tv[7] = '{2'd1, 1'b1, 16, 16'h0101, 16'h8888, 32'd1,         5'h00, 16'd0, 16'd2, 32'd100};
    tv[8] = '{2'd0, 1'b0,  8, 16'h0001, 16'h0088, 32'hFFFF_FFF0, 5'h00, 16'd0, 16'd1, 32'hFFFF_FF9C};
    tv[9] = '{2'd2, 1'b1, 10, 16'h0004, 16'h0220, 32'd1,         5'h01, 16'd2, 16'd1, 32'd52};

    vif.tdata = '0; vif.tkeep = 4'hF; vif.tvalid = 1'b0; vif.tuser = 1'b0; vif.tlast = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (frame_done === 1'b1) pulses++;
        if (chk_en) begin
          vectors++;
          if ({vif.tready, frame_done, frame_checksum, frame_count, err_flags, err_count} !==
              {m.tready, m.done, m.cks, m.fcnt, m.flags, 16'(m.ecnt)}) begin
            fails++;
            $display("FAIL model_cycle t=%0t: got rdy=%b done=%b cks=%h fc=%0d fl=%h ec=%0d, expected rdy=%b done=%b cks=%h fc=%0d fl=%h ec=%0d",
                     $time, vif.tready, frame_done, frame_checksum, frame_count, err_flags, err_count,
                     m.tready, m.done, m.cks, m.fcnt, m.flags, m.ecnt);
          end
        end
      end
    join_none

    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tready", 32'(vif.tready), 32'd0);
    check("reset_count", 32'(frame_count), 32'd0);
    check("reset_flags", 32'(err_flags), 32'd0);
    rstn = 1'b1;
    chk_en = 1;

    // Table-driven frame scenarios.
    for (int i = 0; i < 10; i++) begin
      mode = tv[i].mode;
      do_reset();
      p0 = pulses;
      send_seq(tv[i].n, tv[i].sof, tv[i].eol, tv[i].base, tv[i].gaps);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_flags", i), 32'(err_flags), 32'(tv[i].x_flags));
      check($sformatf("v%0d_errcnt", i), 32'(err_count), 32'(tv[i].x_ecnt));
      check($sformatf("v%0d_frames", i), 32'(frame_count), 32'(tv[i].x_frames));
      check($sformatf("v%0d_checksum", i), frame_checksum, tv[i].x_cks);
      check($sformatf("v%0d_pulses", i), 32'(pulses - p0), 32'(tv[i].x_frames));
    end

    // Timeout while stalled in ACTIVE, then err_clear.
    mode = 2'd2;
    do_reset();
    send_beat(32'h5, 1'b1, 1'b0, 0);
    repeat (19) @(negedge clk);
    check("timeout_before", 32'(err_flags), 32'h00);
    @(negedge clk);
    check("timeout_flag", 32'(err_flags), 32'h10);
    check("timeout_cnt", 32'(err_count), 32'd1);
    repeat (5) @(negedge clk);
    check("timeout_once", 32'(err_count), 32'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("clear_flags", 32'(err_flags), 32'h00);
    check("clear_cnt", 32'(err_count), 32'd0);

    // Mode 3 never ready.
    mode = 2'd0;
    do_reset();
    repeat (2) @(negedge clk);
    mode = 2'd3;
    repeat (5) @(negedge clk);
    check("mode3_tready", 32'(vif.tready), 32'd0);

    // Async reset mid-line, then recovery.
    mode = 2'd0;
    do_reset();
    send_beat(32'd9, 1'b0, 1'b0, 0);
    send_frame(32'd1);
    send_beat(32'd1, 1'b1, 1'b0, 0);
    send_beat(32'd2, 1'b0, 1'b0, 0);
    check("pre_reset_count", 32'(frame_count), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_tready", 32'(vif.tready), 32'd0);
    check("async_outputs", {15'd0, frame_done, frame_count}, 32'd0);
    check("async_checksum", frame_checksum, 32'd0);
    check("async_errs", {11'd0, err_flags, err_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    send_beat(32'd3, 1'b0, 1'b0, 0);
    send_frame(32'd1);
    repeat (2) @(negedge clk);
    check("recover_count", 32'(frame_count), 32'd1);
    check("recover_flags", 32'(err_flags), 32'h01);
    check("recover_checksum", frame_checksum, 32'd36);

    // Randomized traffic against the reference model.
    do_reset();
    rnd_clr = 1;
    for (int f = 0; f < 30; f++) begin
      mode = 2'($urandom_range(0, 2));
      for (int ln = 0; ln < Y; ln++) begin
        for (int w = 0; w < X; w++) begin
          logic u;
          logic l;
          u = (ln == 0 && w == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 23) == 0);
          l = (w == X - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
          send_beat($urandom, u, l, int'($urandom_range(0, 3)));
        end
      end
    end
    rnd_clr = 0;
    err_clear = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
